// File: rtl/x_mod_serial.sv
// Serial Horner reducer: R = X mod M, one SLICE_W-bit slice per clock, MSB slice first.
// Valid/ready handshake on both the operand and the result side.
module x_mod_serial #(
   parameter int unsigned N_BITS  = 400,
   parameter int unsigned SLICE_W = 16,
   parameter int unsigned M       = 241,
   parameter int unsigned K       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] X,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [K-1:0]      R,
   output logic              busy
);

   // 2^w mod m by repeated doubling, evaluated at elaboration time
   function automatic int unsigned pow2_mod(input int unsigned w, input int unsigned m);
      int unsigned p;
      p = 1 % m;
      for (int unsigned i = 0; i < w; i++) p = (p * 2) % m;
      return p;
   endfunction

   localparam int unsigned NSLICE = (N_BITS + SLICE_W - 1) / SLICE_W;
   localparam int unsigned P      = pow2_mod(SLICE_W, M);
   localparam int unsigned SH_W   = NSLICE * SLICE_W;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned PROD_W = 2 * K;
   // acc*P + slice < M*M + 2^SLICE_W, so one bit above the wider term suffices
   localparam int unsigned SUM_W  = ((PROD_W > SLICE_W) ? PROD_W : SLICE_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [SH_W-1:0]    sh;
   logic [K-1:0]       acc;
   logic [CNT_W-1:0]   cnt;

   logic [SLICE_W-1:0] top_c;
   logic [SUM_W-1:0]   sum_c;
   logic [K-1:0]       acc_nxt_c;

   // One Horner step: exact reduction of acc*P + top slice
   always_comb begin
      top_c     = sh[SH_W-1 -: SLICE_W];
      sum_c     = SUM_W'(acc) * SUM_W'(P) + SUM_W'(top_c);
      acc_nxt_c = K'(sum_c % SUM_W'(M));
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)   state_d = S_RUN;
         S_RUN:   if (cnt == '0)  state_d = S_DONE;
         S_DONE:  if (out_ready)  state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sh        <= '0;
         acc       <= '0;
         cnt       <= '0;
         R         <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_d == S_DONE);
         in_ready  <= (state_d == S_IDLE);
         busy      <= (state_d != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  sh  <= SH_W'(X);
                  acc <= '0;
                  cnt <= CNT_W'(NSLICE - 1);
               end
            end
            S_RUN: begin
               acc <= acc_nxt_c;
               sh  <= sh << SLICE_W;
               if (cnt == '0) R   <= acc_nxt_c;
               else           cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
